// File: rtl/lcd_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_frame_sequencer
//  Description : HD44780-compatible 8-bit, 2x16 character LCD sequencer.
//                Runs the power-up wait and initialisation command list on
//                its own, then on each update pulse snapshots both 128-bit
//                line images and streams them to the panel with setup,
//                enable-pulse and execution timing. The panel is write-only.
//                Optional feature macro: LCD_SEQ_PENDING_EN (a 1-deep pending
//                flag remembers an update that arrives while the sequencer
//                is not idle).
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_sequencer #(
    parameter int POWERUP_CYCLES    = 3_000_000,
    parameter int SETUP_CYCLES      = 8,
    parameter int E_PULSE_CYCLES    = 50,
    parameter int CMD_WAIT_CYCLES   = 8000,
    parameter int CLEAR_WAIT_CYCLES = 328_000
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [127:0] line0_data,
    input  logic [127:0] line1_data,
    input  logic         update,
    output logic         ready,
    output logic         busy,
    output logic [7:0]   lcd_data,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The phase counter only ever counts up to (parameter - 1), so it needs
    // just enough bits to hold the largest parameter minus one.
    localparam int c_MAX   = f_max(f_max(f_max(POWERUP_CYCLES, SETUP_CYCLES),
                                         f_max(E_PULSE_CYCLES, CMD_WAIT_CYCLES)),
                                   CLEAR_WAIT_CYCLES);
    localparam int c_CNT_W = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_PWR_LAST = c_CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SET_LAST = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_EHI_LAST = c_CNT_W'(E_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST = c_CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LAST = c_CNT_W'(CLEAR_WAIT_CYCLES - 1);

    localparam logic [5:0] c_INIT_LAST  = 6'd5;
    localparam logic [5:0] c_FRAME_LAST = 6'd33;
    localparam logic [7:0] c_CMD_CLEAR  = 8'h01;
    localparam logic [8:0] c_FIRST_INIT = {1'b0, 8'h38};
    localparam logic [8:0] c_LINE0_ADDR = {1'b0, 8'h80};

    typedef enum logic [1:0] {
        ST_PWRUP = 2'd0,
        ST_INIT  = 2'd1,
        ST_IDLE  = 2'd2,
        ST_FRAME = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHIGH = 2'd1,
        PH_WAIT  = 2'd2
    } phase_t;

    state_t              r_state;
    phase_t              r_phase;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [5:0]          r_idx;
    logic [127:0]        r_shadow0;
    logic [127:0]        r_shadow1;

    logic [c_CNT_W-1:0]  w_wait_last;
    logic                w_in_xfer;
    logic                w_xfer_done;
    logic                w_last_xfer;
    logic                w_seq_done;
    logic                w_restart;
    logic                w_start_frame;
    logic [5:0]          w_next_idx;
    logic [8:0]          w_next_byte;

    // Initialisation command list, indexed by transfer number.
    function automatic logic [7:0] f_init_cmd(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd1, 6'd2: return 8'h38;
            6'd3:             return 8'h0C;
            6'd4:             return c_CMD_CLEAR;
            default:          return 8'h06;
        endcase
    endfunction

    // Frame transfer list as {rs, data}: address, 16 chars, address, 16 chars.
    function automatic logic [8:0] f_frame_byte(input logic [5:0]   idx,
                                                input logic [127:0] l0,
                                                input logic [127:0] l1);
        logic [6:0] sel;
        int         k;
        k   = int'(idx);
        sel = 7'd0;
        if (k == 0) begin
            return c_LINE0_ADDR;
        end else if (k <= 16) begin
            sel = 7'(8 * (16 - k));
            return {1'b1, l0[sel +: 8]};
        end else if (k == 17) begin
            return {1'b0, 8'hC0};
        end else if (k <= 33) begin
            sel = 7'(8 * (33 - k));
            return {1'b1, l1[sel +: 8]};
        end
        return 9'h000;
    endfunction

    // Clear needs the long execution wait; everything else uses the short one.
    assign w_wait_last   = (!lcd_rs && (lcd_data == c_CMD_CLEAR)) ? c_CLR_LAST : c_CMD_LAST;
    assign w_in_xfer     = (r_state == ST_INIT) || (r_state == ST_FRAME);
    assign w_xfer_done   = w_in_xfer && (r_phase == PH_WAIT) && (r_cnt == w_wait_last);
    assign w_last_xfer   = (r_state == ST_INIT) ? (r_idx == c_INIT_LAST) : (r_idx == c_FRAME_LAST);
    assign w_seq_done    = w_xfer_done && w_last_xfer;
    assign w_next_idx    = r_idx + 6'd1;
    assign w_next_byte   = (r_state == ST_INIT) ? {1'b0, f_init_cmd(w_next_idx)}
                                                : f_frame_byte(w_next_idx, r_shadow0, r_shadow1);
    assign w_start_frame = ((r_state == ST_IDLE) && update) || (w_seq_done && w_restart);

`ifdef LCD_SEQ_PENDING_EN
    logic r_pending;

    // Remember one update seen outside IDLE; consumed when a sequence ends.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pending <= 1'b0;
        end else if (w_seq_done) begin
            r_pending <= 1'b0;
        end else if (update && (r_state != ST_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    // An update coinciding with the final wait cycle restarts directly too.
    assign w_restart = r_pending || update;
`else
    assign w_restart = 1'b0;
`endif

    assign lcd_rw = 1'b0;

    // Main sequencer: state, phase timing, transfer index and LCD bus drive.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= ST_PWRUP;
            r_phase   <= PH_SETUP;
            r_cnt     <= '0;
            r_idx     <= 6'd0;
            r_shadow0 <= '0;
            r_shadow1 <= '0;
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
        end else begin
            if ((r_state == ST_INIT) && w_seq_done) begin
                ready <= 1'b1;
            end

            if (w_start_frame) begin
                r_shadow0          <= line0_data;
                r_shadow1          <= line1_data;
                r_state            <= ST_FRAME;
                r_phase            <= PH_SETUP;
                r_cnt              <= '0;
                r_idx              <= 6'd0;
                {lcd_rs, lcd_data} <= c_LINE0_ADDR;
                lcd_e              <= 1'b0;
                busy               <= 1'b1;
            end else begin
                case (r_state)
                    ST_PWRUP: begin
                        if (r_cnt == c_PWR_LAST) begin
                            r_state            <= ST_INIT;
                            r_phase            <= PH_SETUP;
                            r_cnt              <= '0;
                            r_idx              <= 6'd0;
                            {lcd_rs, lcd_data} <= c_FIRST_INIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    ST_INIT, ST_FRAME: begin
                        case (r_phase)
                            PH_SETUP: begin
                                if (r_cnt == c_SET_LAST) begin
                                    r_phase <= PH_EHIGH;
                                    r_cnt   <= '0;
                                    lcd_e   <= 1'b1;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            PH_EHIGH: begin
                                if (r_cnt == c_EHI_LAST) begin
                                    r_phase <= PH_WAIT;
                                    r_cnt   <= '0;
                                    lcd_e   <= 1'b0;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            PH_WAIT: begin
                                if (w_xfer_done) begin
                                    r_cnt <= '0;
                                    if (w_last_xfer) begin
                                        r_state <= ST_IDLE;
                                        r_phase <= PH_SETUP;
                                        busy    <= 1'b0;
                                    end else begin
                                        r_idx              <= w_next_idx;
                                        r_phase            <= PH_SETUP;
                                        {lcd_rs, lcd_data} <= w_next_byte;
                                    end
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_phase <= PH_SETUP;
                                r_cnt   <= '0;
                            end
                        endcase
                    end

                    default: begin
                        // IDLE: bus holds its last value until the next frame.
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
